// File: rtl/render_pkg.sv
// Shared types, colours, ghost offsets and sprite mask for the layer renderer.
package render_pkg;

  typedef logic [8:0]        rgb9_t;
  typedef logic signed [12:0] coord_t;

  localparam rgb9_t COL_BLACK   = 9'h000;
  localparam rgb9_t COL_BALL    = 9'h1FF;
  localparam rgb9_t COL_GHOST   = 9'h092;
  localparam rgb9_t COL_PAD_BOT = 9'h1C0;
  localparam rgb9_t COL_PAD_TOP = 9'h007;
  localparam rgb9_t COL_BRICK1  = 9'h1FF;
  localparam rgb9_t COL_BRICK2  = 9'h1C0;
  localparam rgb9_t COL_BRICK3  = 9'h03F;

  localparam logic [2:0] STATE_AIM = 3'd2;

  // Ghost offsets from ball 0, indexed by aim angle
  localparam coord_t GHOST_DX [8] = '{-13'sd51, -13'sd40, -13'sd25, 13'sd25,
                                       13'sd40,  13'sd51,  13'sd40, 13'sd40};
  localparam coord_t GHOST_DY [8] = '{-13'sd25, -13'sd40, -13'sd51, -13'sd51,
                                      -13'sd40, -13'sd25, -13'sd40, -13'sd40};

  localparam int PAD_TOP_Y_LO = 20;
  localparam int PAD_TOP_Y_HI = 30;
  localparam int PAD_BOT_Y_LO = 570;
  localparam int PAD_BOT_Y_HI = 580;

  // Rounded plus shape inside a square of half-extent radius
  function automatic logic sprite_mask(input coord_t dx, input coord_t dy, input int radius);
    int ax;
    int ay;
    ax = (dx < 0) ? -int'(dx) : int'(dx);
    ay = (dy < 0) ? -int'(dy) : int'(dy);
    return (ax <= radius) && (ay <= radius) &&
           ((ax == 0) || (ay == 0) || (ax <= 2 && ay <= 3) || (ax <= 3 && ay <= 2));
  endfunction

  function automatic rgb9_t brick_colour(input logic [1:0] t);
    case (t)
      2'd1:    return COL_BRICK1;
      2'd2:    return COL_BRICK2;
      2'd3:    return COL_BRICK3;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/layer_renderer_if.sv
// Pixel stream between VGA timing generator, renderer and DAC pins.
interface layer_renderer_if;
  logic [10:0] x;
  logic [9:0]  y;
  logic        o_active;
  logic        frame_start;
  logic [8:0]  VGA;
  logic        pix_active;

  modport master (output x, y, o_active, frame_start, input VGA, pix_active);
  modport slave  (input x, y, o_active, frame_start, output VGA, pix_active);
endinterface

// File: rtl/sprite_hit.sv
// Registered sprite mask test around a centre point; one-cycle latency.
module sprite_hit
  import render_pkg::*;
#(
  parameter int RADIUS = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  input  coord_t px_i,
  input  coord_t py_i,
  input  coord_t cx_i,
  input  coord_t cy_i,
  output logic   hit_o
);

  logic hit_q, hit_d;

  always_comb hit_d = en_i && sprite_mask(px_i - cx_i, py_i - cy_i, RADIUS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit_d;
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/layer_renderer.sv
// Three-stage layered pixel renderer for the brick game.
// Optional hit-flash on the last struck brick: define RENDER_FLASH_EN.
module layer_renderer
  import render_pkg::*;
#(
  parameter int BRICK_COLS   = 8,
  parameter int BRICK_ROWS   = 8,
  parameter int BRICK_W      = 100,
  parameter int BRICK_H      = 50,
  parameter int BRICK_MARGIN = 5,
  parameter int GRID_Y_MAX   = 400,
  parameter int N_BALLS      = 2,
  parameter int RADIUS       = 4,
  parameter int PADDLE_HALF  = 80,
  parameter int FLASH_FRAMES = 8,
  localparam int N_BRICKS    = BRICK_COLS * BRICK_ROWS,
  localparam int IDX_W       = $clog2(N_BRICKS)
) (
  input  logic                    clk,
  input  logic                    rst,
  layer_renderer_if.slave         pix,
  input  logic [2:0]              state,
  input  logic [2:0]              angle,
  input  logic [10:0]             x_paddle_l,
  input  logic [10:0]             x_paddle_r,
  input  logic [11*N_BALLS-1:0]   x_ball,
  input  logic [10*N_BALLS-1:0]   y_ball,
  input  logic [N_BALLS-1:0]      ball_en,
  input  logic [2*N_BRICKS-1:0]   brick,
  input  logic                    hit_valid,
  input  logic [IDX_W-1:0]        hit_idx
);

  // S1: coordinates, cell decode, ghost position
  logic [10:0] px_q, bx_q, ox_q;
  logic [9:0]  py_q, by_q, oy_q;
  logic        act1_q;
  logic [2:0]  state_q;
  coord_t      gx_q, gy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q <= '0; py_q <= '0; act1_q <= 1'b0; state_q <= '0;
      bx_q <= '0; by_q <= '0; ox_q <= '0; oy_q <= '0;
      gx_q <= '0; gy_q <= '0;
    end else begin
      px_q    <= pix.x;
      py_q    <= pix.y;
      act1_q  <= pix.o_active;
      state_q <= state;
      bx_q    <= 11'(pix.x / BRICK_W);
      by_q    <= 10'(pix.y / BRICK_H);
      ox_q    <= 11'((pix.x / BRICK_W) * BRICK_W);
      oy_q    <= 10'((pix.y / BRICK_H) * BRICK_H);
      gx_q    <= coord_t'({2'b00, x_ball[10:0]}) + GHOST_DX[angle];
      gy_q    <= coord_t'({3'b000, y_ball[9:0]}) + GHOST_DY[angle];
    end
  end

  // S2: per-layer hit flags
  coord_t px_s, py_s, dpl, dpr;
  int     cell_idx;
  logic   in_grid, inset, flash_match;
  logic   pad_l_d, pad_r_d, brick_d, blank_d;
  logic [1:0] btype_d;

  logic [N_BALLS-1:0] ball_hit;
  logic               ghost_hit;

  assign px_s = coord_t'({2'b00, px_q});
  assign py_s = coord_t'({3'b000, py_q});

  for (genvar i = 0; i < N_BALLS; i++) begin : g_ball
    sprite_hit #(.RADIUS(RADIUS)) u_ball (
      .clk  (clk),
      .rst  (rst),
      .en_i (ball_en[i]),
      .px_i (px_s),
      .py_i (py_s),
      .cx_i (coord_t'({2'b00, x_ball[11*i +: 11]})),
      .cy_i (coord_t'({3'b000, y_ball[10*i +: 10]})),
      .hit_o(ball_hit[i])
    );
  end

  sprite_hit #(.RADIUS(RADIUS)) u_ghost (
    .clk  (clk),
    .rst  (rst),
    .en_i (state_q == STATE_AIM),
    .px_i (px_s),
    .py_i (py_s),
    .cx_i (gx_q),
    .cy_i (gy_q),
    .hit_o(ghost_hit)
  );

  always_comb begin
    dpl      = px_s - coord_t'({2'b00, x_paddle_l});
    dpr      = px_s - coord_t'({2'b00, x_paddle_r});
    pad_l_d  = (int'(dpl) <= PADDLE_HALF) && (int'(dpl) >= -PADDLE_HALF) &&
               (int'(py_q) > PAD_TOP_Y_LO) && (int'(py_q) <= PAD_TOP_Y_HI);
    pad_r_d  = (int'(dpr) <= PADDLE_HALF) && (int'(dpr) >= -PADDLE_HALF) &&
               (int'(py_q) > PAD_BOT_Y_LO) && (int'(py_q) <= PAD_BOT_Y_HI);
    in_grid  = (int'(bx_q) < BRICK_COLS) && (int'(by_q) < BRICK_ROWS);
    cell_idx = in_grid ? (int'(by_q) * BRICK_COLS + int'(bx_q)) : 0;
    btype_d  = brick[2*cell_idx +: 2];
    inset    = (int'(px_q) >= int'(ox_q) + BRICK_MARGIN) &&
               (int'(px_q) <  int'(ox_q) + BRICK_W - BRICK_MARGIN) &&
               (int'(py_q) >= int'(oy_q) + BRICK_MARGIN) &&
               (int'(py_q) <  int'(oy_q) + BRICK_H - BRICK_MARGIN) &&
               (int'(py_q) <  GRID_Y_MAX);
    // A flashing cell still draws after its brick has been cleared
    brick_d  = inset && in_grid && ((btype_d != 2'd0) || flash_match);
    blank_d  = !act1_q || (px_q == '0) || (py_q == '0) || (state_q < STATE_AIM);
  end

`ifdef RENDER_FLASH_EN
  localparam int FC_W = $clog2(FLASH_FRAMES + 1);
  logic [FC_W-1:0]  flash_cnt_q, flash_cnt_d;
  logic [IDX_W-1:0] flash_idx_q, flash_idx_d;

  always_comb begin
    flash_cnt_d = flash_cnt_q;
    flash_idx_d = flash_idx_q;
    if (hit_valid) begin
      flash_idx_d = hit_idx;
      flash_cnt_d = FC_W'(FLASH_FRAMES);
    end else if (pix.frame_start && flash_cnt_q != '0) begin
      flash_cnt_d = flash_cnt_q - FC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_cnt_q <= '0;
      flash_idx_q <= '0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      flash_idx_q <= flash_idx_d;
    end
  end

  assign flash_match = (flash_cnt_q != '0) && in_grid && (IDX_W'(cell_idx) == flash_idx_q);
`else
  logic unused_flash_inputs;
  assign unused_flash_inputs = ^{hit_valid, hit_idx, pix.frame_start};
  assign flash_match = 1'b0;
`endif

  logic       pad_l_q, pad_r_q, brick_q, flash_q, blank_q, act2_q;
  logic [1:0] btype_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_l_q <= 1'b0; pad_r_q <= 1'b0; brick_q <= 1'b0; flash_q <= 1'b0;
      blank_q <= 1'b1; act2_q  <= 1'b0; btype_q <= '0;
    end else begin
      pad_l_q <= pad_l_d;
      pad_r_q <= pad_r_d;
      brick_q <= brick_d;
      flash_q <= flash_match;
      blank_q <= blank_d;
      act2_q  <= act1_q;
      btype_q <= btype_d;
    end
  end

  // S3: priority select
  rgb9_t colour, brick_col, vga_d, vga_q;
  logic  pix_active_q;

  always_comb begin
    colour    = COL_BLACK;
    brick_col = brick_colour((btype_q == 2'd0) ? 2'd1 : btype_q);
    if (flash_q) brick_col = ~brick_col;
    if (|ball_hit)      colour = COL_BALL;
    else if (ghost_hit) colour = COL_GHOST;
    else if (pad_r_q)   colour = COL_PAD_BOT;
    else if (pad_l_q)   colour = COL_PAD_TOP;
    else if (brick_q)   colour = brick_col;
    vga_d = blank_q ? COL_BLACK : colour;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_q        <= '0;
      pix_active_q <= 1'b0;
    end else begin
      vga_q        <= vga_d;
      pix_active_q <= act2_q;
    end
  end

  assign pix.VGA        = vga_q;
  assign pix.pix_active = pix_active_q;

endmodule

// File: doc/layer_renderer.md
# layer_renderer

Pipelined per-pixel colour generator for the brick game, replacing the single-stage OR-combined renderer. It sits between the VGA timing generator and the DAC pins. It draws a parametrised brick grid, N balls, two paddles and the aiming ghost with fixed layer priority, and adds a timed hit-flash on the most recently struck brick. Output is registered 3 cycles after the pixel coordinate.

## Interface
- `BRICK_COLS`, 8: grid columns.
- `BRICK_ROWS`, 8: grid rows.
- `BRICK_W`, 100: cell width in px.
- `BRICK_H`, 50: cell height in px.
- `BRICK_MARGIN`, 5: inset of each brick inside its cell.
- `GRID_Y_MAX`, 400: no brick drawn at y ≥ this.
- `N_BALLS`, 2: ball sprite count, 1..4.
- `RADIUS`, 4: ball half-extent.
- `PADDLE_HALF`, 80: paddle half-length.
- `FLASH_FRAMES`, 8: flash duration in frames.
- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `x` in 11: pixel column.
- `y` in 10: pixel row.
- `o_active` in 1: visible-area flag, aligned with `x`/`y`.
- `frame_start` in 1: one-cycle pulse per frame.
- `state` in 3: game state; 2 = aiming, ≥3 = play.
- `angle` in 3: aim index.
- `x_paddle_l` in 11: top paddle centre.
- `x_paddle_r` in 11: bottom paddle centre.
- `x_ball` in 11·N_BALLS: packed ball x values; ball 0 in the LSBs.
- `y_ball` in 10·N_BALLS: packed ball y values.
- `ball_en` in N_BALLS: per-ball draw enable.
- `brick` in 2·COLS·ROWS: brick type; index = row·COLS+col, 0 = empty.
- `hit_valid` in 1: brick-hit strobe.
- `hit_idx` in $clog2(COLS·ROWS): index of the struck brick.
- `VGA` out 9: RGB 3:3:3, red in the MSBs.
- `pix_active` out 1: `o_active` delayed to match `VGA`.

## Operation
- S1 registers:
  - `bx = x / BRICK_W` and `by = y / BRICK_H` (constant divisors);
  - the cell origins;
  - `x`, `y`, `o_active`;
  - ghost position from `angle` (offsets from ball 0): 0:(−51,−25), 1:(−40,−40), 2:(−25,−51), 3:(+25,−51), 4:(+40,−40), 5:(+51,−25), 6/7:(+40,−40).
- S2 registers one hit flag per layer:
  - ball[i]: `ball_en[i]`, inside ±RADIUS, and the plus/rounded mask (centre row or column; |dx|≤2 and |dy|≤3; or |dx|≤3 and |dy|≤2).
  - ghost: same mask around the ghost position, only when `state==2`.
  - top paddle: |x−x_paddle_l| ≤ PADDLE_HALF and 20<y≤30.
  - bottom paddle: same test against `x_paddle_r` with 570<y≤580.
  - brick: inside the cell inset by BRICK_MARGIN on every side; y<GRID_Y_MAX; bx<COLS; by<ROWS; type≠0.
- All coordinate arithmetic is signed 13-bit, so a sprite near x=0 or y=0 never wraps.
- S3 selects colour by priority, highest first:
  - ball: 0x1FF;
  - ghost: 0x092;
  - bottom paddle: 0x1C0;
  - top paddle: 0x007;
  - brick: type 1 = 0x1FF, type 2 = 0x1C0, type 3 = 0x03F; a flashing brick is inverted;
  - otherwise 0.
- `VGA` = 0 when delayed `o_active`=0, when x=0 or y=0, or when `state`<2.
- Flash state:
  - `hit_valid` loads `flash_idx ← hit_idx` and `flash_cnt ← FLASH_FRAMES`.
  - `frame_start` decrements `flash_cnt` while it is nonzero.
  - Flash is active while `flash_cnt` ≠ 0 and the pixel's index equals `flash_idx`.
- Boundary cases:
  - `hit_valid` and `frame_start` in the same cycle: the load wins.
  - A new hit during a flash restarts the flash on the new index.
  - A flash still draws if the brick has become empty: type treated as 1, then inverted to 0x000 (black).

## Timing
- Latency is exactly 3 clk from `x`/`y`/`o_active` to `VGA`/`pix_active`. Throughput is 1 pixel per clk.
- Game inputs (`state`, balls, paddles, `brick`) are sampled in S1 and assumed stable within a line.
- Reset: all pipeline registers, `VGA`=0, `pix_active`=0, `flash_cnt`=0, `flash_idx`=0.
- Reset deassertion mid-frame: black output until valid data has filled all 3 stages. No resynchronisation to the frame.

## Configuration
- `RENDER_FLASH_EN` defined: flash logic as above.
- Not defined:
  - `hit_valid`, `hit_idx` and `frame_start` are ignored;
  - the flash registers are absent;
  - brick colours are never inverted;
  - all other behaviour is identical.

## Structure
- Package `render_pkg`:
  - `rgb9_t`;
  - colour constants;
  - ghost offset table;
  - paddle row bounds (20/30, 570/580);
  - function `sprite_mask(dx, dy, radius)`.
- Sub-module `sprite_hit`, instantiated N_BALLS+1 times (balls plus ghost): registered mask test, one-cycle latency.

## Test plan
- Ball 0 at (400,300), `state`=3, pixel (400,300), `o_active`=1 → `VGA`=0x1FF 3 cycles later. Pixel (404,304) → 0.
- Ball at (2,300), pixel (1,300) → 0x1FF with no wrap. Pixel (2046,300) → 0.
- `state`=2, `angle`=1, ball (400,500), pixel (360,460) → 0x092. Same pixel with `state`=3 → 0.
- `brick[9]`=2, pixel (150,70) → 0x1C0. Pixel (103,70), in the margin → 0. Pixel (150,420) → 0.
- Ball overlapping brick 9 → 0x1FF; ball beats brick in priority.
- `RENDER_FLASH_EN` defined: `hit_valid`, `hit_idx`=9 → pixel (150,70)=0x03F for 8 `frame_start` pulses, then 0x1C0. `rst` pulse mid-flash → `flash_cnt`=0 and `VGA`=0 immediately.
